// File: rtl/pc_pkg.sv
// Shared defaults and the next-PC select encoding for the fetch PC unit.
// The return-address stack is present only when PC_UNIT_RAS_EN is defined.
package pc_pkg;

    localparam int              PC_WIDTH_DEF     = 32;
    localparam longint unsigned RESET_VECTOR_DEF = 64'd0;
    localparam longint unsigned INCREMENT_DEF    = 64'd4;
    localparam int              RAS_DEPTH_DEF    = 4;

    typedef enum logic [2:0] {
        SEL_HOLD,
        SEL_SEQ,
        SEL_BRANCH,
        SEL_REDIR,
        SEL_RET
    } pc_sel_e;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: push, pop, or replace-top when both arrive together.
// A push into a full stack overwrites the oldest entry; overflow and underflow pulse err_o.
module pc_ras
    import pc_pkg::*;
#(
    parameter int WIDTH = PC_WIDTH_DEF,
    parameter int DEPTH = RAS_DEPTH_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] push_data_i,
    output logic [WIDTH-1:0] top_o,
    output logic             empty_o,
    output logic             err_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W-1:0] top_idx;
    logic [PTR_W-1:0] wr_idx;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             wr_en;
    logic             empty;
    logic             full;

    // ptr_q is the next free slot; the top entry sits just below it.
    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CNT_MAX);
    assign top_idx = ptr_q - 1'b1;

    always_comb begin
        ptr_d  = ptr_q;
        cnt_d  = cnt_q;
        err_d  = 1'b0;
        wr_en  = 1'b0;
        wr_idx = ptr_q;
        if (push_i && pop_i && !empty) begin
            wr_en  = 1'b1;
            wr_idx = top_idx;
        end else if (push_i) begin
            wr_en = 1'b1;
            ptr_d = ptr_q + 1'b1;
            if (full) begin
                err_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            if (pop_i) begin
                err_d = 1'b1;
            end
        end else if (pop_i) begin
            if (empty) begin
                err_d = 1'b1;
            end else begin
                ptr_d = top_idx;
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    // Entry storage needs no reset: it is only read while the count is non-zero.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wr_idx] <= push_data_i;
        end
    end

    assign top_o   = mem_q[top_idx];
    assign empty_o = empty;
    assign err_o   = err_q;

endmodule

// File: rtl/pc_unit.sv
// Fetch program counter with stall-time redirect buffer and optional return-address
// stack (enabled by defining PC_UNIT_RAS_EN; otherwise CALL/RET are ignored).
module pc_unit
    import pc_pkg::*;
#(
    parameter int                  PC_WIDTH     = PC_WIDTH_DEF,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = PC_WIDTH'(RESET_VECTOR_DEF),
    parameter logic [PC_WIDTH-1:0] INCREMENT    = PC_WIDTH'(INCREMENT_DEF),
    parameter int                  RAS_DEPTH    = RAS_DEPTH_DEF
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                BUSYWAIT,
    input  logic                BRANCH,
    input  logic [PC_WIDTH-1:0] BRANCH_TARGET,
    input  logic                CALL,
    input  logic                RET,
    output logic [PC_WIDTH-1:0] PC,
    output logic [PC_WIDTH-1:0] PC_NEXT_SEQ,
    output logic                REDIRECT_PENDING,
    output logic                RAS_EMPTY,
    output logic                RAS_ERR
);

    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [PC_WIDTH-1:0] redir_tgt_q, redir_tgt_d;
    logic                redir_vld_q, redir_vld_d;
    logic [PC_WIDTH-1:0] seq_pc;
    logic [PC_WIDTH-1:0] ras_top;
    logic                ras_push;
    logic                ras_pop;
    logic                ras_empty;
    logic                ras_err;
    pc_sel_e             sel;

    assign seq_pc = pc_q + INCREMENT;

    // A RET only pops when nothing of higher priority redirects this edge,
    // except alongside a CALL, where it becomes a replace-top.
    assign ras_push = !BUSYWAIT && BRANCH && CALL;
    assign ras_pop  = !BUSYWAIT && RET && (ras_push || (!BRANCH && !redir_vld_q));

    always_comb begin
        sel = SEL_SEQ;
        if (BUSYWAIT) begin
            sel = SEL_HOLD;
        end else if (ras_pop && !ras_empty) begin
            sel = SEL_RET;
        end else if (BRANCH) begin
            sel = SEL_BRANCH;
        end else if (redir_vld_q) begin
            sel = SEL_REDIR;
        end
    end

    always_comb begin
        pc_d        = pc_q;
        redir_vld_d = redir_vld_q;
        redir_tgt_d = redir_tgt_q;
        case (sel)
            SEL_HOLD:   pc_d = pc_q;
            SEL_SEQ:    pc_d = seq_pc;
            SEL_BRANCH: pc_d = BRANCH_TARGET;
            SEL_REDIR:  pc_d = redir_tgt_q;
            SEL_RET:    pc_d = ras_top;
            default:    pc_d = pc_q;
        endcase
        if (BUSYWAIT) begin
            if (BRANCH) begin
                redir_vld_d = 1'b1;
                redir_tgt_d = BRANCH_TARGET;
            end
        end else begin
            redir_vld_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            pc_q        <= RESET_VECTOR;
            redir_vld_q <= 1'b0;
            redir_tgt_q <= '0;
        end else begin
            pc_q        <= pc_d;
            redir_vld_q <= redir_vld_d;
            redir_tgt_q <= redir_tgt_d;
        end
    end

`ifdef PC_UNIT_RAS_EN
    pc_ras #(
        .WIDTH (PC_WIDTH),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk_i       (CLK),
        .rst_i       (RESET),
        .push_i      (ras_push),
        .pop_i       (ras_pop),
        .push_data_i (seq_pc),
        .top_o       (ras_top),
        .empty_o     (ras_empty),
        .err_o       (ras_err)
    );
`else
    logic unused_ras;
    assign ras_top    = '0;
    assign ras_empty  = 1'b1;
    assign ras_err    = 1'b0;
    assign unused_ras = ras_push ^ RAS_DEPTH[0];
`endif

    assign PC               = pc_q;
    assign PC_NEXT_SEQ      = seq_pc;
    assign REDIRECT_PENDING = redir_vld_q;
    assign RAS_EMPTY        = ras_empty;
    assign RAS_ERR          = ras_err;

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: directed scenarios plus random traffic against a
// queue-based reference model; RAS expectations follow PC_UNIT_RAS_EN.
module tb_pc_unit;

    localparam int DEPTH = 4;
`ifdef PC_UNIT_RAS_EN
    localparam bit RAS_EN = 1'b1;
`else
    localparam bit RAS_EN = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RESET;
    logic        BUSYWAIT, BRANCH, CALL, RET;
    logic [31:0] BRANCH_TARGET;
    logic [31:0] PC, PC_NEXT_SEQ;
    logic        REDIRECT_PENDING, RAS_EMPTY, RAS_ERR;

    logic       busy8, br8;
    logic [7:0] tgt8, pc8, nseq8;
    logic       pend8, empty8, err8;

    always #5 CLK = ~CLK;

    pc_unit dut (
        .CLK(CLK), .RESET(RESET), .BUSYWAIT(BUSYWAIT), .BRANCH(BRANCH),
        .BRANCH_TARGET(BRANCH_TARGET), .CALL(CALL), .RET(RET),
        .PC(PC), .PC_NEXT_SEQ(PC_NEXT_SEQ), .REDIRECT_PENDING(REDIRECT_PENDING),
        .RAS_EMPTY(RAS_EMPTY), .RAS_ERR(RAS_ERR)
    );

    pc_unit #(.PC_WIDTH(8)) dut8 (
        .CLK(CLK), .RESET(RESET), .BUSYWAIT(busy8), .BRANCH(br8),
        .BRANCH_TARGET(tgt8), .CALL(1'b0), .RET(1'b0),
        .PC(pc8), .PC_NEXT_SEQ(nseq8), .REDIRECT_PENDING(pend8),
        .RAS_EMPTY(empty8), .RAS_ERR(err8)
    );

    typedef struct {
        logic [31:0] pc;
        bit          pend;
        bit          empty;
        bit          err;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model: architectural PC, redirect buffer, and a plain queue as the stack.
    logic [31:0] m_pc, m_tgt;
    bit          m_pend, m_err;
    logic [31:0] m_stack[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, req, $time);
    endtask

    task automatic model_reset();
        m_pc   = 32'h0;
        m_tgt  = 32'h0;
        m_pend = 1'b0;
        m_err  = 1'b0;
        m_stack.delete();
    endtask

    task automatic model_edge(input bit busy, input bit br, input bit call, input bit ret,
                              input logic [31:0] tgt);
        logic [31:0] link;
        logic [31:0] old;
        link  = m_pc + 32'd4;
        m_err = 1'b0;
        if (busy) begin
            if (br) begin
                m_pend = 1'b1;
                m_tgt  = tgt;
            end
        end else begin
            if (RAS_EN && br && call && ret && m_stack.size() > 0) begin
                old         = m_stack[$];
                m_stack[$]  = link;
                m_pc        = old;
            end else if (br) begin
                if (RAS_EN && call) begin
                    if (m_stack.size() == DEPTH) begin
                        void'(m_stack.pop_front());
                        m_err = 1'b1;
                    end
                    m_stack.push_back(link);
                end
                m_pc = tgt;
            end else if (m_pend) begin
                m_pc = m_tgt;
            end else if (RAS_EN && ret) begin
                if (m_stack.size() > 0) begin
                    m_pc = m_stack.pop_back();
                end else begin
                    m_pc  = link;
                    m_err = 1'b1;
                end
            end else begin
                m_pc = link;
            end
            m_pend = 1'b0;
        end
    endtask

    // Called at a negedge; drives one edge of stimulus and returns at the next negedge.
    task automatic step(input bit busy, input bit br, input bit call, input bit ret,
                        input logic [31:0] tgt);
        exp_t e;
        BUSYWAIT      = busy;
        BRANCH        = br;
        CALL          = call;
        RET           = ret;
        BRANCH_TARGET = tgt;
        model_edge(busy, br, call, ret, tgt);
        e.pc    = m_pc;
        e.pend  = m_pend;
        e.empty = (m_stack.size() == 0);
        e.err   = m_err;
        exp_q.push_back(e);
        @(posedge CLK);
        @(negedge CLK);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("pc", PC, e.pc);
                check("pc_next_seq", PC_NEXT_SEQ, e.pc + 32'd4);
                check("redirect_pending", {31'b0, REDIRECT_PENDING}, {31'b0, e.pend});
                check("ras_empty", {31'b0, RAS_EMPTY}, {31'b0, e.empty});
                check("ras_err", {31'b0, RAS_ERR}, {31'b0, e.err});
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench timeout");
    end

    initial begin : stim
        bit          busy, br, call, ret;
        logic [31:0] tgt;

        RESET = 1'b1; BUSYWAIT = 1'b0; BRANCH = 1'b0; CALL = 1'b0; RET = 1'b0;
        BRANCH_TARGET = '0; busy8 = 1'b0; br8 = 1'b0; tgt8 = '0;
        model_reset();

        repeat (2) @(posedge CLK);
        #1;
        check("rst_pc", PC, 32'h0);
        check("rst_next_seq", PC_NEXT_SEQ, 32'h4);
        check("rst_pending", {31'b0, REDIRECT_PENDING}, 32'h0);
        check("rst_empty", {31'b0, RAS_EMPTY}, 32'h1);
        check("rst_err", {31'b0, RAS_ERR}, 32'h0);
        @(negedge CLK);
        RESET = 1'b0;

        // Sequential fetch out of reset: 0x4, 0x8, 0xC, 0x10.
        repeat (4) step(0, 0, 0, 0, 32'h0);

        // Stall three edges with a branch captured on the second.
        step(1, 0, 0, 0, 32'h0);
        step(1, 1, 0, 0, 32'h80);
        step(1, 0, 0, 0, 32'h0);
        step(0, 0, 0, 0, 32'h0);

        // Live branch beats a buffered redirect.
        step(1, 1, 0, 0, 32'h80);
        step(0, 1, 0, 0, 32'h200);

        // Call/return.
        step(0, 1, 0, 0, 32'h20);
        step(0, 1, 1, 0, 32'h100);
        step(0, 0, 0, 0, 32'h0);
        step(0, 0, 0, 1, 32'h0);

        // Overflow on the fifth call, underflow on the fifth return.
        for (int i = 0; i < 5; i++) step(0, 1, 1, 0, 32'h1000 * (i + 1));
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 32'h0);

        // Simultaneous CALL and RET replace the top entry.
        step(0, 1, 1, 0, 32'h300);
        step(0, 1, 1, 1, 32'h400);
        step(0, 0, 0, 1, 32'h0);

        // CALL/RET are ignored while stalled.
        step(1, 0, 0, 1, 32'h0);
        step(1, 1, 1, 0, 32'h500);
        step(0, 0, 0, 0, 32'h0);

        // 32-bit wrap.
        step(0, 1, 0, 0, 32'hFFFF_FFFC);
        step(0, 0, 0, 0, 32'h0);

        // Reset asserted mid-stall with a pending redirect.
        step(1, 1, 0, 0, 32'h600);
        #2;
        BRANCH = 1'b0;
        RESET  = 1'b1;
        #1;
        check("midrst_pc", PC, 32'h0);
        check("midrst_pending", {31'b0, REDIRECT_PENDING}, 32'h0);
        check("midrst_empty", {31'b0, RAS_EMPTY}, 32'h1);
        model_reset();
        @(posedge CLK);
        #1;
        check("midrst_hold_pc", PC, 32'h0);
        @(negedge CLK);
        RESET = 1'b0;
        step(0, 0, 0, 0, 32'h0);
        step(0, 0, 0, 0, 32'h0);

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            busy = ($urandom_range(3) == 0);
            br   = ($urandom_range(4) == 0);
            call = br && ($urandom_range(1) == 1);
            ret  = !br && !m_pend && ($urandom_range(3) == 0);
            tgt  = {22'b0, 8'($urandom_range(255)), 2'b00};
            step(busy, br, call, ret, tgt);
        end

        // 8-bit instance wraps 0xFC -> 0x00.
        br8  = 1'b1;
        tgt8 = 8'hFC;
        @(posedge CLK);
        #1;
        check("w8_pc", {24'b0, pc8}, 32'hFC);
        check("w8_next_seq", {24'b0, nseq8}, 32'h00);
        @(negedge CLK);
        br8 = 1'b0;
        @(posedge CLK);
        #1;
        check("w8_wrap_pc", {24'b0, pc8}, 32'h00);
        check("w8_wrap_next_seq", {24'b0, nseq8}, 32'h04);

        @(posedge CLK);
        #2;
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 32, width of all address signals.
REQ-002 SHALL have parameter RESET_VECTOR, default 0, PC value loaded by reset.
REQ-003 SHALL have parameter INCREMENT, default 4, sequential step in bytes.
REQ-004 SHALL have parameter RAS_DEPTH, default 4, return-address-stack entries (power of 2, ≥2).
REQ-005 SHALL have port CLK  in  1  the only clock; all state updates on its rising edge.
REQ-006 SHALL have port RESET  in  1  asynchronous, active-high reset.
REQ-007 SHALL have port BUSYWAIT  in  1  stall; PC holds while high.
REQ-008 SHALL have port BRANCH  in  1  redirect request (branch/jump/call taken).
REQ-009 SHALL have port BRANCH_TARGET  in  PC_WIDTH  redirect address.
REQ-010 SHALL have port CALL  in  1  push link address (qualified with BRANCH).
REQ-011 SHALL have port RET  in  1  pop return address and redirect to it.
REQ-012 SHALL have port PC  out  PC_WIDTH  current fetch address (registered).
REQ-013 SHALL have port PC_NEXT_SEQ  out  PC_WIDTH  PC+INCREMENT, combinational.
REQ-014 SHALL have port REDIRECT_PENDING  out  1  buffered redirect waiting for stall end.
REQ-015 SHALL have port RAS_EMPTY  out  1  stack holds no entries.
REQ-016 SHALL have port RAS_ERR  out  1  one-cycle pulse on push-overwrite or pop-when-empty.

Function
REQ-017 SHALL, on a non-stalled edge, select next PC by priority: live BRANCH target > buffered redirect > RET pop (stack non-empty) > PC+INCREMENT.
REQ-018 SHALL, on a stalled edge, hold PC; a BRANCH seen while stalled SHALL be captured into the redirect buffer, with the latest capture overwriting earlier ones.
REQ-019 SHALL assert REDIRECT_PENDING from the edge after capture until the first non-stalled edge, which consumes and clears the buffer.
REQ-020 SHALL, when a live BRANCH coincides with a non-empty buffer on a non-stalled edge, take the live target and discard the buffer.
REQ-021 SHALL ignore CALL and RET on stalled edges (no push, no pop).
REQ-022 SHALL, on a non-stalled edge with CALL and BRANCH, push PC+INCREMENT and jump to BRANCH_TARGET.
REQ-023 SHALL, on RET when empty, continue to PC+INCREMENT and pulse RAS_ERR.
REQ-024 SHALL, on push when full, overwrite the oldest entry (circular pointer wrap), keep count at RAS_DEPTH, and pulse RAS_ERR.
REQ-025 SHALL, on simultaneous CALL and RET, replace the top entry with PC+INCREMENT and jump to the old top value (count unchanged).
REQ-026 SHALL compute all PC arithmetic modulo 2^PC_WIDTH (wrap from max to low without flag).
REQ-027 SHALL have PC latency of one edge from request to new PC visible.

Reset
REQ-028 SHALL, while RESET is high, force PC=RESET_VECTOR, REDIRECT_PENDING=0, RAS_EMPTY=1, RAS_ERR=0, stack count=0, independent of CLK.
REQ-029 SHALL, on RESET asserted mid-stall or with a pending redirect, discard the buffer; the first edge after release with BUSYWAIT=0 SHALL load RESET_VECTOR+INCREMENT.

Configuration
REQ-030 SHALL compile the return-address stack only when macro PC_UNIT_RAS_EN is defined.
REQ-031 SHALL, without PC_UNIT_RAS_EN, keep all ports, ignore CALL/RET, tie RAS_EMPTY=1 and RAS_ERR=0.

Structure
REQ-032 SHALL place default widths, RESET_VECTOR, INCREMENT and the next-PC-select enumeration in shared package pc_pkg.
REQ-033 SHALL implement the stack as sub-module pc_ras (push/pop/replace, count, pointer, empty/full, err).

Verification
REQ-034 SHALL cover reset: RESET=1 for 2 cycles, release, BUSYWAIT=0 -> PC 0x0, then 0x4, 0x8.
REQ-035 SHALL cover stall capture: PC=0x10, BUSYWAIT=1 for 3 cycles, BRANCH target 0x80 in cycle 2 -> PC holds 0x10, REDIRECT_PENDING=1, next free edge PC=0x80.
REQ-036 SHALL cover live-vs-buffered: buffer holds 0x80, release stall with BRANCH 0x200 -> PC=0x200, pending cleared.
REQ-037 SHALL cover call/return: at PC=0x20 CALL+BRANCH 0x100 -> PC 0x100; later RET -> PC 0x24, RAS_EMPTY=1.
REQ-038 SHALL cover overflow/underflow: 5 calls with RAS_DEPTH=4 -> RAS_ERR pulse on 5th; 5 RETs -> 4 correct targets, 5th gives PC+4 and RAS_ERR.
REQ-039 SHALL cover wrap: PC_WIDTH=8, PC=0xFC -> next PC 0x00.
